pipe_ctrl: RTL and testbench

Pipeline control unit for the 5-stage core. It merges per-stage stall requests into one stall vector, and sequences multi-cycle EX operations by holding the pipeline for a programmed number of cycles. It also registers branch/exception flushes with a redirect PC, and keeps a stall-cycle counter plus a stall watchdog. It sits beside the IF/ID/EX/MEM/WB registers and drives their stall/flush inputs.

---
 rtl/pipe_ctrl.sv | 98 +++++++++
 tb/tb_pipe_ctrl.sv | 124 ++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges stage stall requests, sequences multi-cycle EX ops, registers flushes, tracks stall statistics
module pipe_ctrl #(
  parameter int TIMEOUT_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        ex_mc_start,
  input  logic [5:0]  ex_mc_len,
  input  logic        flush_req,
  input  logic [31:0] flush_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        ex_mc_done,
  output logic        busy,
  output logic [31:0] stall_cycles,
  output logic        timeout
);
  typedef enum logic [1:0] {RUN, MC_WAIT, FLUSH} state_t;
  localparam logic [5:0] EX_HOLD = 6'b001111;
  localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;
  localparam logic [TIMEOUT_W-1:0] WD_TRIP = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
  state_t state_q, state_d;
  logic [5:0] cnt_q, cnt_d, base, mc_len;
  logic [31:0] pc_q, pc_d, sc_q;
  logic flush_q, timeout_q;
  logic [TIMEOUT_W-1:0] wd_q;
  // Highest requesting stage holds itself and everything upstream
  always_comb begin
    base = stallreq_mem ? 6'b011111 : stallreq_ex ? 6'b001111 :
           stallreq_id  ? 6'b000111 : stallreq_if ? 6'b000011 : 6'b000000;
    mc_len = (ex_mc_len == 6'd0) ? 6'd1 : ex_mc_len;
  end
  // Next state, op counter, redirect latch and combinational stall/done
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pc_d = pc_q;
    stall = base;
    ex_mc_done = 1'b0;
    if (flush_req) begin
      state_d = FLUSH;
      pc_d = flush_pc;
      cnt_d = 6'd0;
    end
    case (state_q)
      RUN: if (!flush_req && ex_mc_start) begin
        stall = base | EX_HOLD;
        cnt_d = mc_len;
        state_d = MC_WAIT;
      end
      MC_WAIT: if (cnt_q != 6'd1) begin
        stall = base | EX_HOLD;
        if (!flush_req) cnt_d = cnt_q - 6'd1;
      end else begin
        ex_mc_done = !flush_req;
        if (!flush_req && !stallreq_mem) begin
          state_d = RUN;
          cnt_d = 6'd0;
        end
      end
      FLUSH: begin
        stall = 6'b000000;
        if (!flush_req) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end
  // State, redirect, stall statistics and sticky watchdog
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q <= 6'd0;
      pc_q <= 32'd0;
      flush_q <= 1'b0;
      sc_q <= 32'd0;
      wd_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pc_q <= pc_d;
      flush_q <= flush_req;
      sc_q <= sc_q + {31'd0, |stall};
      wd_q <= !(|stall) ? '0 : (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
      timeout_q <= timeout_q | ((|stall) && wd_q == WD_TRIP);
    end
  end
  assign flush = flush_q;
  assign new_pc = pc_q;
  assign busy = state_q != RUN;
  assign stall_cycles = sc_q;
  assign timeout = timeout_q;
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed and randomized checks of pipe_ctrl against a cycle-level behavioural model
module tb_pipe_ctrl;
  localparam int TW = 4;
  logic clk = 0, rst = 1;
  logic s_if = 0, s_id = 0, s_ex = 0, s_mem = 0, start = 0, freq = 0;
  logic [5:0] len = 0;
  logic [31:0] fpc = 0;
  logic [5:0] stall;
  logic flush, done, busy, timeout;
  logic [31:0] new_pc, scyc;
  int checks = 0, errors = 0;
  bit m_flush, m_mc, m_to;
  int m_hold, m_consec;
  logic [31:0] m_pc, m_sc;

  pipe_ctrl #(.TIMEOUT_W(TW)) dut (
    .clk(clk), .rst(rst), .stallreq_if(s_if), .stallreq_id(s_id), .stallreq_ex(s_ex),
    .stallreq_mem(s_mem), .ex_mc_start(start), .ex_mc_len(len), .flush_req(freq),
    .flush_pc(fpc), .stall(stall), .flush(flush), .new_pc(new_pc), .ex_mc_done(done),
    .busy(busy), .stall_cycles(scyc), .timeout(timeout));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_flush = 0; m_mc = 0; m_to = 0; m_hold = 0; m_consec = 0; m_pc = 0; m_sc = 0;
  endtask

  task automatic step();
    logic [5:0] base, es;
    bit ed, eb;
    @(negedge clk);
    base = s_mem ? 6'h1f : s_ex ? 6'h0f : s_id ? 6'h07 : s_if ? 6'h03 : 6'h00;
    ed = 0;
    if (m_flush) begin es = 0; eb = 1; end
    else if (m_mc) begin
      eb = 1;
      es = (m_hold > 0) ? (base | 6'h0f) : base;
      ed = (m_hold == 0) && !freq;
    end else begin
      eb = 0;
      es = (start && !freq) ? (base | 6'h0f) : base;
    end
    chk("stall", 32'(stall), 32'(es));
    chk("ex_mc_done", 32'(done), 32'(ed));
    chk("busy", 32'(busy), 32'(eb));
    chk("flush", 32'(flush), 32'(m_flush));
    chk("new_pc", new_pc, m_pc);
    chk("stall_cycles", scyc, m_sc);
    chk("timeout", 32'(timeout), 32'(m_to));
    if (rst) model_reset();
    else begin
      if (freq) begin m_flush = 1; m_pc = fpc; m_mc = 0; end
      else if (m_flush) m_flush = 0;
      else if (m_mc) begin
        if (m_hold > 0) m_hold--;
        else if (!s_mem) m_mc = 0;
      end else if (start) begin
        m_mc = 1;
        m_hold = ((len == 0) ? 1 : int'(len)) - 1;
      end
      if (es != 0) begin m_sc++; m_consec++; end else m_consec = 0;
      if (m_consec >= (1 << TW) - 1) m_to = 1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    s_if = 0; s_id = 0; s_ex = 0; s_mem = 0; start = 0; freq = 0; rst = 0;
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    step();
    s_if = 1; step();
    s_ex = 1; step();
    idle(); s_mem = 1; step();
    idle(); repeat (2) step();
    start = 1; len = 4; step();
    start = 0; repeat (5) step();
    start = 1; len = 0; step();
    start = 0; s_mem = 1; repeat (2) step();
    s_mem = 0; repeat (2) step();
    start = 1; len = 8; step();
    start = 0; step();
    freq = 1; fpc = 32'h4000; step();
    freq = 0; repeat (10) step();
    freq = 1; fpc = 32'h100; step();
    fpc = 32'h200; step();
    freq = 0; repeat (3) step();
    start = 1; len = 6; step();
    start = 0; step();
    rst = 1; step();
    rst = 0; repeat (2) step();
    s_id = 1; repeat (20) step();
    s_id = 0; repeat (3) step();
    rst = 1; step();
    rst = 0; step();
    for (int i = 0; i < 600; i++) begin
      s_if = ($urandom_range(0, 3) == 0);
      s_id = ($urandom_range(0, 5) == 0);
      s_ex = ($urandom_range(0, 7) == 0);
      s_mem = ($urandom_range(0, 5) == 0);
      start = ($urandom_range(0, 5) == 0);
      len = 6'($urandom_range(0, 9));
      freq = ($urandom_range(0, 15) == 0);
      fpc = $urandom;
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    idle(); step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
